seq_det_ctrl: RTL and testbench

//   Front-end controller for the serial pattern detector. Accepts parallel words over a

---
 rtl/seq_det_ctrl_pkg.sv | 25 ++
 rtl/seq_pattern_matcher.sv | 53 +++++
 rtl/seq_det_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and constants for the serial pattern detector front-end.
package seq_det_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_e;

  localparam int                     DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b0110;

  // Ceiling log2, never less than 1 so it can size a counter directly.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/seq_pattern_matcher.sv
// Sliding-window serial pattern matcher with a saturating fill counter so that
// no match is reported before PAT_LEN real bits have been seen.
module seq_pattern_matcher
  import seq_det_ctrl_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic bit_i,
  input  logic bit_en_i,
  output logic match_o
);

  localparam int FILL_W = clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] window_q, window_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               match_q, match_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    if (clear_i) begin
      window_d = '0;
      fill_d   = '0;
    end else if (bit_en_i) begin
      window_d = {window_q[PAT_LEN-2:0], bit_i};
      fill_d   = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);
      match_d  = (window_d == PATTERN) && (fill_d == FILL_W'(PAT_LEN));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_q <= '0;
      fill_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-bit serializer feeding a pattern matcher, with a saturating match
// counter and an optional threshold interrupt (enabled by SEQ_DET_CTRL_IRQ_EN).
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int                 WORD_W  = 8,
  parameter int                 CNT_W   = 8,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  input  logic [CNT_W-1:0]  thresh,
  output logic              irq,
  input  logic              irq_ack
);

  localparam int BC_W = clog2(WORD_W);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              shift_en;
  logic              last_bit;
  logic              match;

  assign last_bit = (bit_cnt_q == BC_W'(WORD_W - 1));

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    shift_en  = 1'b0;
    in_ready  = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      sreg_d    = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            sreg_d    = in_data;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          shift_en  = 1'b1;
          sreg_d    = sreg_q << 1;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (last_bit) begin
            // Accepting on the last bit keeps back-to-back words gap-free.
            in_ready  = 1'b1;
            bit_cnt_d = '0;
            if (in_valid) begin
              sreg_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          sreg_d    = '0;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  seq_pattern_matcher #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_matcher (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear),
    .bit_i    (sreg_q[WORD_W-1]),
    .bit_en_i (shift_en),
    .match_o  (match)
  );

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (match && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy        = (state_q == SHIFT);
  assign match_pulse = match;
  assign match_count = count_q;

`ifdef SEQ_DET_CTRL_IRQ_EN
  logic irq_q, irq_d;
  logic bump_q;

  // bump_q marks that the count changed on the previous edge, so irq only
  // fires on a transition into the threshold, not while sitting on it.
  always_comb begin
    irq_d = irq_q;
    if (clear) begin
      irq_d = 1'b0;
    end else if (bump_q && (count_q == thresh) && (thresh != '0)) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q  <= 1'b0;
      bump_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      bump_q <= !clear && (count_d != count_q);
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{thresh, irq_ack};
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: per-cycle vector table plus hand-written
// multi-cycle sequences for clear, saturation and the threshold interrupt.
module tb_seq_det_ctrl;

`ifdef SEQ_DET_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       match_pulse;
  logic [7:0] match_count;
  logic [7:0] thresh;
  logic       irq;
  logic       irq_ack;

  int n_checks = 0;
  int n_fail   = 0;

  seq_det_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .thresh      (thresh),
    .irq         (irq),
    .irq_ack     (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_match;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic v, input logic [7:0] d,
                              input logic r, input logic b, input logic m,
                              input logic [7:0] n);
    vec_t x;
    x.clr = c; x.valid = v; x.data = d;
    x.exp_ready = r; x.exp_busy = b; x.exp_match = m; x.exp_count = n;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Offers one word, then runs its 8 shift cycles and counts match pulses.
  task automatic send_word(input logic [7:0] w, output int pulses);
    int guard;
    pulses   = 0;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pulses += int'(match_pulse);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int total;
    logic exp_irq;
    exp_irq = IRQ_EN;

    // Test 1: single word 0x36.
    vecs.push_back(mk(0, 1, 8'h36, 1, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 2));
    // Clear in IDLE: in_ready drops in the clear cycle.
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0));
    // Test 2: 0x03 then 0x00 back-to-back, match spans the word boundary.
    vecs.push_back(mk(0, 1, 8'h03, 1, 1, 0, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1));

    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    thresh   = '0;
    irq_ack  = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_match", 32'(match_pulse), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[k]) begin
      clear    = vecs[k].clr;
      in_valid = vecs[k].valid;
      in_data  = vecs[k].data;
      #1;
      check($sformatf("vec%0d_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
      tick();
      check($sformatf("vec%0d_busy", k), 32'(busy), 32'(vecs[k].exp_busy));
      check($sformatf("vec%0d_match", k), 32'(match_pulse), 32'(vecs[k].exp_match));
      check($sformatf("vec%0d_count", k), 32'(match_count), 32'(vecs[k].exp_count));
    end
    clear    = 1'b0;
    in_valid = 1'b0;

    // Test 3: 0x66 gives two matches, 0xFF and 0x00 give none.
    do_clear();
    send_word(8'h66, p);
    check("t3_66_pulses", 32'(p), 32'd2);
    send_word(8'hFF, p);
    check("t3_ff_pulses", 32'(p), 32'd0);
    send_word(8'h00, p);
    check("t3_00_pulses", 32'(p), 32'd0);
    tick();
    check("t3_count", 32'(match_count), 32'd2);

    // Test 4: clear on bit 3 of 0x66 discards the word and its history.
    in_valid = 1'b1;
    in_data  = 8'h66;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t4_busy_pre", 32'(busy), 32'd1);
    check("t4_count_pre", 32'(match_count), 32'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_busy_post", 32'(busy), 32'd0);
    check("t4_count_post", 32'(match_count), 32'd0);
    check("t4_match_post", 32'(match_pulse), 32'd0);
    send_word(8'h06, p);
    check("t4_06_pulses", 32'(p), 32'd1);
    tick();
    check("t4_count_final", 32'(match_count), 32'd1);

    // Test 5: counter saturates at 255 over 300 matches.
    do_clear();
    total = 0;
    for (int w = 0; w < 150; w++) begin
      send_word(8'h66, p);
      total += p;
      if (w == 126) begin
        tick();
        check("t5_count_254", 32'(match_count), 32'd254);
      end else if (w == 127) begin
        tick();
        check("t5_count_255", 32'(match_count), 32'd255);
      end
    end
    tick();
    check("t5_total_pulses", 32'(total), 32'd300);
    check("t5_count_sat", 32'(match_count), 32'd255);

    // Test 6: threshold interrupt.
    do_clear();
    thresh = 8'd3;
    send_word(8'h66, p);
    tick();
    check("t6_count2", 32'(match_count), 32'd2);
    check("t6_irq_below", 32'(irq), 32'd0);
    send_word(8'h06, p);
    tick();
    check("t6_count3", 32'(match_count), 32'd3);
    check("t6_irq_not_yet", 32'(irq), 32'd0);
    tick();
    check("t6_irq_set", 32'(irq), 32'(exp_irq));
    thresh = 8'd0;
    tick();
    check("t6_irq_thresh_live", 32'(irq), 32'(exp_irq));
    thresh  = 8'd3;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("t6_irq_acked", 32'(irq), 32'd0);
    send_word(8'h66, p);
    tick();
    tick();
    check("t6_count5", 32'(match_count), 32'd5);
    check("t6_irq_no_reraise", 32'(irq), 32'd0);
    do_clear();
    send_word(8'h66, p);
    send_word(8'h06, p);
    irq_ack = 1'b1;
    tick();
    check("t6_irq_ack_early", 32'(irq), 32'd0);
    tick();
    check("t6_irq_set_wins", 32'(irq), 32'(exp_irq));
    tick();
    irq_ack = 1'b0;
    check("t6_irq_ack_after", 32'(irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
